msrv32_csr_file: RTL and testbench

- Machine-mode CSR file for the msrv32 core. It sits in pipeline stage 2, directly downstream of the stage-1/2 pipeline register.
- Consumes the registered CSR address, CSR op, CSR write enable, rs1 value and immediate produced by that pipeline register.
- Returns CSR read data to the stage-2 writeback mux.
- Holds trap state (mepc/mcause/mtval/mstatus) and the 64-bit cycle/instret counters.

---
 rtl/msrv32_csr_pkg.sv | 60 ++++++
 rtl/msrv32_csr_counter64.sv | 29 ++
 rtl/msrv32_csr_file.sv | 191 +++++++++++++++++++
 tb/tb_msrv32_csr_file.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_csr_pkg.sv
// Shared CSR constants for the msrv32 machine-mode CSR file.
// Counter CSRs are built only when MSRV32_CSR_COUNTERS_EN is defined.
package msrv32_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [2:0] CSR_OP_NONE  = 3'b000;
  localparam logic [2:0] CSR_OP_RW    = 3'b001;
  localparam logic [2:0] CSR_OP_RS    = 3'b010;
  localparam logic [2:0] CSR_OP_RC    = 3'b011;
  localparam logic [2:0] CSR_OP_NONEI = 3'b100;
  localparam logic [2:0] CSR_OP_RWI   = 3'b101;
  localparam logic [2:0] CSR_OP_RSI   = 3'b110;
  localparam logic [2:0] CSR_OP_RCI   = 3'b111;

  localparam logic [3:0] MCAUSE_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] MCAUSE_ILLEGAL_INSTR    = 4'd2;
  localparam logic [3:0] MCAUSE_BREAKPOINT       = 4'd3;
  localparam logic [3:0] MCAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] MCAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] MCAUSE_ECALL_M          = 4'd11;
  localparam logic [3:0] MCAUSE_M_SW_IRQ         = 4'd3;
  localparam logic [3:0] MCAUSE_M_TIMER_IRQ      = 4'd7;
  localparam logic [3:0] MCAUSE_M_EXT_IRQ        = 4'd11;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LSB  = 11;
  localparam int MSTATUS_MPP_MSB  = 12;
  localparam logic [1:0] MSTATUS_MPP_M = 2'b11;

  // Same positions in mie and mip.
  localparam int MIX_MSI_BIT = 3;
  localparam int MIX_MTI_BIT = 7;
  localparam int MIX_MEI_BIT = 11;

  function automatic logic [31:0] csr_apply_op(input logic [2:0]  op,
                                               input logic [31:0] old_val,
                                               input logic [31:0] operand);
    case (op)
      CSR_OP_RW, CSR_OP_RWI: return operand;
      CSR_OP_RS, CSR_OP_RSI: return old_val | operand;
      CSR_OP_RC, CSR_OP_RCI: return old_val & ~operand;
      default:               return old_val;
    endcase
  endfunction

endpackage

// File: rtl/msrv32_csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
// A write to either half takes precedence over the increment for that cycle.
module msrv32_csr_counter64 (
  input  logic        ms_risc32_mp_clk_in,
  input  logic        ms_risc32_mp_rst_in,
  input  logic        inc_in,
  input  logic        wr_lo_en_in,
  input  logic        wr_hi_en_in,
  input  logic [31:0] wr_data_in,
  output logic [63:0] count_out
);

  logic [63:0] count_reg;

  always_ff @(posedge ms_risc32_mp_clk_in) begin
    if (ms_risc32_mp_rst_in) begin
      count_reg <= '0;
    end else if (wr_lo_en_in) begin
      count_reg[31:0] <= wr_data_in;
    end else if (wr_hi_en_in) begin
      count_reg[63:32] <= wr_data_in;
    end else if (inc_in) begin
      count_reg <= count_reg + 64'd1;
    end
  end

  assign count_out = count_reg;

endmodule

// File: rtl/msrv32_csr_file.sv
// Machine-mode CSR file for msrv32 pipeline stage 2: trap state, interrupt
// enables/pending, and optional cycle/instret counters (MSRV32_CSR_COUNTERS_EN).
module msrv32_csr_file
  import msrv32_csr_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0
) (
  input  logic        ms_risc32_mp_clk_in,
  input  logic        ms_risc32_mp_rst_in,
  input  logic [11:0] csr_addr_in,
  input  logic [2:0]  csr_op_in,
  input  logic        csr_wr_en_in,
  input  logic [31:0] rs1_in,
  input  logic [4:0]  csr_uimm_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] iaddr_in,
  input  logic        e_irq_in,
  input  logic        t_irq_in,
  input  logic        s_irq_in,
  input  logic        set_cause_in,
  input  logic        i_or_e_in,
  input  logic [3:0]  cause_in,
  input  logic        set_epc_in,
  input  logic        mret_in,
  input  logic        instret_inc_in,
  output logic [31:0] csr_data_out,
  output logic [31:0] mepc_out,
  output logic [31:0] trap_address_out,
  output logic        mie_out,
  output logic        meie_out,
  output logic        mtie_out,
  output logic        msie_out,
  output logic        meip_out,
  output logic        mtip_out,
  output logic        msip_out,
  output logic        illegal_csr_out
);

  logic        mstatus_mie_reg, mstatus_mpie_reg;
  logic [2:0]  mie_reg, mip_reg;  // {external, timer, software}
  logic [31:0] mtvec_reg, mepc_reg, mcause_reg, mtval_reg, mscratch_reg;
  logic [31:0] mstatus_val, mie_val, mip_val, rd_val, operand, wr_val;
  logic        addr_valid, csr_write;
  logic        wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;
  logic        unused_bits;

`ifdef MSRV32_CSR_COUNTERS_EN
  logic [63:0] mcycle_count, minstret_count;
  logic        wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;
  assign unused_bits = ^pc_in[1:0];
`else
  assign unused_bits = ^{pc_in[1:0], instret_inc_in};
`endif

  always_comb begin
    mstatus_val = '0;
    mstatus_val[MSTATUS_MPP_MSB:MSTATUS_MPP_LSB] = MSTATUS_MPP_M;
    mstatus_val[MSTATUS_MIE_BIT]  = mstatus_mie_reg;
    mstatus_val[MSTATUS_MPIE_BIT] = mstatus_mpie_reg;
    mie_val = '0;
    mie_val[MIX_MEI_BIT] = mie_reg[2];
    mie_val[MIX_MTI_BIT] = mie_reg[1];
    mie_val[MIX_MSI_BIT] = mie_reg[0];
    mip_val = '0;
    mip_val[MIX_MEI_BIT] = mip_reg[2];
    mip_val[MIX_MTI_BIT] = mip_reg[1];
    mip_val[MIX_MSI_BIT] = mip_reg[0];
  end

  // Counter addresses stay legal even when the counters are not built.
  always_comb begin
    rd_val     = '0;
    addr_valid = 1'b1;
    case (csr_addr_in)
      CSR_MSTATUS:  rd_val = mstatus_val;
      CSR_MIE:      rd_val = mie_val;
      CSR_MTVEC:    rd_val = mtvec_reg;
      CSR_MSCRATCH: rd_val = mscratch_reg;
      CSR_MEPC:     rd_val = mepc_reg;
      CSR_MCAUSE:   rd_val = mcause_reg;
      CSR_MTVAL:    rd_val = mtval_reg;
      CSR_MIP:      rd_val = mip_val;
      CSR_MHARTID:  rd_val = HART_ID;
`ifdef MSRV32_CSR_COUNTERS_EN
      CSR_MCYCLE:    rd_val = mcycle_count[31:0];
      CSR_MCYCLEH:   rd_val = mcycle_count[63:32];
      CSR_MINSTRET:  rd_val = minstret_count[31:0];
      CSR_MINSTRETH: rd_val = minstret_count[63:32];
`else
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: rd_val = '0;
`endif
      default:      addr_valid = 1'b0;
    endcase
  end

  assign operand   = csr_op_in[2] ? {27'b0, csr_uimm_in} : rs1_in;
  assign wr_val    = csr_apply_op(csr_op_in, rd_val, operand);
  assign csr_write = csr_wr_en_in && addr_valid && (csr_op_in[1:0] != 2'b00);

  assign wr_mstatus  = csr_write && (csr_addr_in == CSR_MSTATUS);
  assign wr_mie      = csr_write && (csr_addr_in == CSR_MIE);
  assign wr_mtvec    = csr_write && (csr_addr_in == CSR_MTVEC);
  assign wr_mscratch = csr_write && (csr_addr_in == CSR_MSCRATCH);
  assign wr_mepc     = csr_write && (csr_addr_in == CSR_MEPC);
  assign wr_mcause   = csr_write && (csr_addr_in == CSR_MCAUSE);
  assign wr_mtval    = csr_write && (csr_addr_in == CSR_MTVAL);

  always_ff @(posedge ms_risc32_mp_clk_in) begin
    if (ms_risc32_mp_rst_in) begin
      mstatus_mie_reg  <= 1'b0;
      mstatus_mpie_reg <= 1'b1;
      mie_reg          <= '0;
      mip_reg          <= '0;
      mtvec_reg        <= {RESET_MTVEC[31:2], 2'b00};
      mepc_reg         <= '0;
      mcause_reg       <= '0;
      mtval_reg        <= '0;
      mscratch_reg     <= '0;
    end else begin
      mip_reg <= {e_irq_in, t_irq_in, s_irq_in};

      // Trap entry beats MRET, which beats a software write.
      if (set_cause_in) begin
        mstatus_mpie_reg <= mstatus_mie_reg;
        mstatus_mie_reg  <= 1'b0;
      end else if (mret_in) begin
        mstatus_mie_reg  <= mstatus_mpie_reg;
        mstatus_mpie_reg <= 1'b1;
      end else if (wr_mstatus) begin
        mstatus_mie_reg  <= wr_val[MSTATUS_MIE_BIT];
        mstatus_mpie_reg <= wr_val[MSTATUS_MPIE_BIT];
      end

      if (set_cause_in) begin
        mcause_reg <= {i_or_e_in, 27'b0, cause_in};
        mtval_reg  <= iaddr_in;
      end else begin
        if (wr_mcause) mcause_reg <= wr_val;
        if (wr_mtval)  mtval_reg  <= wr_val;
      end

      if (set_epc_in)   mepc_reg <= {pc_in[31:2], 2'b00};
      else if (wr_mepc) mepc_reg <= {wr_val[31:2], 2'b00};

      if (wr_mtvec)    mtvec_reg    <= {wr_val[31:2], 2'b00};
      if (wr_mscratch) mscratch_reg <= wr_val;
      if (wr_mie)      mie_reg      <= {wr_val[MIX_MEI_BIT], wr_val[MIX_MTI_BIT], wr_val[MIX_MSI_BIT]};
    end
  end

`ifdef MSRV32_CSR_COUNTERS_EN
  assign wr_mcycle    = csr_write && (csr_addr_in == CSR_MCYCLE);
  assign wr_mcycleh   = csr_write && (csr_addr_in == CSR_MCYCLEH);
  assign wr_minstret  = csr_write && (csr_addr_in == CSR_MINSTRET);
  assign wr_minstreth = csr_write && (csr_addr_in == CSR_MINSTRETH);

  msrv32_csr_counter64 u_mcycle (
    .ms_risc32_mp_clk_in (ms_risc32_mp_clk_in),
    .ms_risc32_mp_rst_in (ms_risc32_mp_rst_in),
    .inc_in              (1'b1),
    .wr_lo_en_in         (wr_mcycle),
    .wr_hi_en_in         (wr_mcycleh),
    .wr_data_in          (wr_val),
    .count_out           (mcycle_count)
  );

  msrv32_csr_counter64 u_minstret (
    .ms_risc32_mp_clk_in (ms_risc32_mp_clk_in),
    .ms_risc32_mp_rst_in (ms_risc32_mp_rst_in),
    .inc_in              (instret_inc_in),
    .wr_lo_en_in         (wr_minstret),
    .wr_hi_en_in         (wr_minstreth),
    .wr_data_in          (wr_val),
    .count_out           (minstret_count)
  );
`endif

  assign csr_data_out     = rd_val;
  assign mepc_out         = mepc_reg;
  assign trap_address_out = {mtvec_reg[31:2], 2'b00};
  assign mie_out          = mstatus_mie_reg;
  assign meie_out         = mie_reg[2];
  assign mtie_out         = mie_reg[1];
  assign msie_out         = mie_reg[0];
  assign meip_out         = mip_reg[2];
  assign mtip_out         = mip_reg[1];
  assign msip_out         = mip_reg[0];
  assign illegal_csr_out  = csr_wr_en_in && !addr_valid && !ms_risc32_mp_rst_in;

endmodule

// File: tb/tb_msrv32_csr_file.sv
// Self-checking bench for msrv32_csr_file: table-driven CSR ops plus trap,
// priority, counter (MSRV32_CSR_COUNTERS_EN aware), illegal and reset sequences.
module tb_msrv32_csr_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_addr;
  logic [2:0]  csr_op;
  logic        csr_wr_en;
  logic [31:0] rs1;
  logic [4:0]  csr_uimm;
  logic [31:0] pc, iaddr;
  logic        e_irq, t_irq, s_irq;
  logic        set_cause, i_or_e, set_epc, mret, instret_inc;
  logic [3:0]  cause;
  logic [31:0] csr_data, mepc, trap_address;
  logic        mie, meie, mtie, msie, meip, mtip, msip, illegal_csr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [11:0] addr;
    logic [2:0]  op;
    logic [31:0] rs1v;
    logic [4:0]  uimm;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[16];

  always #5 clk = ~clk;

  msrv32_csr_file #(.RESET_MTVEC(32'h100), .HART_ID(32'h5)) dut (
    .ms_risc32_mp_clk_in (clk),
    .ms_risc32_mp_rst_in (rst),
    .csr_addr_in         (csr_addr),
    .csr_op_in           (csr_op),
    .csr_wr_en_in        (csr_wr_en),
    .rs1_in              (rs1),
    .csr_uimm_in         (csr_uimm),
    .pc_in               (pc),
    .iaddr_in            (iaddr),
    .e_irq_in            (e_irq),
    .t_irq_in            (t_irq),
    .s_irq_in            (s_irq),
    .set_cause_in        (set_cause),
    .i_or_e_in           (i_or_e),
    .cause_in            (cause),
    .set_epc_in          (set_epc),
    .mret_in             (mret),
    .instret_inc_in      (instret_inc),
    .csr_data_out        (csr_data),
    .mepc_out            (mepc),
    .trap_address_out    (trap_address),
    .mie_out             (mie),
    .meie_out            (meie),
    .mtie_out            (mtie),
    .msie_out            (msie),
    .meip_out            (meip),
    .mtip_out            (mtip),
    .msip_out            (msip),
    .illegal_csr_out     (illegal_csr)
  );

  task automatic push_exp(input string nm, input logic [31:0] exp);
    exp_t e;
    e.name = nm;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] act);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %h with nothing expected", act);
      return;
    end
    e = sb_q.pop_front();
    if (act !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", e.name, act, e.exp);
    end else begin
      $display("ok   %s: %h", e.name, act);
    end
  endtask

  // Combinational read of one CSR with no write in flight.
  task automatic expect_read(input string nm, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr  = addr;
    csr_op    = 3'b000;
    csr_wr_en = 1'b0;
    push_exp(nm, exp);
    #1;
    pop_cmp(csr_data);
  endtask

  task automatic expect_sig(input string nm, input logic [31:0] act, input logic [31:0] exp);
    push_exp(nm, exp);
    pop_cmp(act);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; the write commits at the next edge.
  task automatic csr_write(input logic [11:0] addr, input logic [2:0] op,
                           input logic [31:0] rs1v, input logic [4:0] uimm);
    csr_addr  = addr;
    csr_op    = op;
    csr_wr_en = 1'b1;
    rs1       = rs1v;
    csr_uimm  = uimm;
    #1;
    expect_sig("illegal_on_write", {31'b0, illegal_csr}, 32'h0);
    @(posedge clk);
    #1;
    csr_wr_en = 1'b0;
    csr_op    = 3'b000;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; csr_addr = CSR_MIP_ADDR(); csr_op = 3'b000; csr_wr_en = 1'b0;
    rs1 = '0; csr_uimm = '0; pc = '0; iaddr = '0;
    e_irq = 0; t_irq = 0; s_irq = 0; set_cause = 0; i_or_e = 0; cause = '0;
    set_epc = 0; mret = 0; instret_inc = 0;

    vecs[0]  = '{12'h340, 3'b001, 32'hDEAD_BEEF, 5'h00, 32'hDEAD_BEEF};
    vecs[1]  = '{12'h340, 3'b010, 32'h0000_0010, 5'h00, 32'hDEAD_BEFF};
    vecs[2]  = '{12'h340, 3'b011, 32'hF000_0000, 5'h00, 32'h0EAD_BEFF};
    vecs[3]  = '{12'h340, 3'b111, 32'hFFFF_FFFF, 5'h1F, 32'h0EAD_BEE0};
    vecs[4]  = '{12'h340, 3'b110, 32'hFFFF_FFFF, 5'h00, 32'h0EAD_BEE0};
    vecs[5]  = '{12'h340, 3'b100, 32'hFFFF_FFFF, 5'h1F, 32'h0EAD_BEE0};
    vecs[6]  = '{12'h340, 3'b000, 32'h0000_0000, 5'h00, 32'h0EAD_BEE0};
    vecs[7]  = '{12'h340, 3'b101, 32'hFFFF_FFFF, 5'h15, 32'h0000_0015};
    vecs[8]  = '{12'h305, 3'b001, 32'h0000_0203, 5'h00, 32'h0000_0200};
    vecs[9]  = '{12'h341, 3'b001, 32'h1234_5677, 5'h00, 32'h1234_5674};
    vecs[10] = '{12'h304, 3'b001, 32'hFFFF_FFFF, 5'h00, 32'h0000_0888};
    vecs[11] = '{12'h344, 3'b001, 32'hFFFF_FFFF, 5'h00, 32'h0000_0000};
    vecs[12] = '{12'hF14, 3'b001, 32'hFFFF_FFFF, 5'h00, 32'h0000_0005};
    vecs[13] = '{12'h343, 3'b010, 32'h0000_A5A5, 5'h00, 32'h0000_A5A5};
    vecs[14] = '{12'h342, 3'b001, 32'h8000_000B, 5'h00, 32'h8000_000B};
    vecs[15] = '{12'h304, 3'b011, 32'h0000_0080, 5'h00, 32'h0000_0808};

    // Reset: illegal must stay low even with a bogus access present.
    csr_addr = 12'h7C0; csr_wr_en = 1'b1; csr_op = 3'b001;
    repeat (3) @(posedge clk);
    #1;
    expect_sig("illegal_during_reset", {31'b0, illegal_csr}, 32'h0);
    csr_wr_en = 1'b0; csr_op = 3'b000;
    sync();
    rst = 1'b0;
    expect_read("reset_mtvec", 12'h305, 32'h0000_0100);
    expect_read("reset_mstatus", 12'h300, 32'h0000_1880);
    expect_read("reset_mepc", 12'h341, 32'h0);
    expect_read("reset_mscratch", 12'h340, 32'h0);
    expect_sig("reset_trap_address", trap_address, 32'h100);
    expect_sig("reset_mie_out", {31'b0, mie}, 32'h0);

    sync();
    for (int i = 0; i < 16; i++) begin
      csr_write(vecs[i].addr, vecs[i].op, vecs[i].rs1v, vecs[i].uimm);
      expect_read($sformatf("vec%0d_addr%h_op%0d", i, vecs[i].addr, vecs[i].op),
                  vecs[i].addr, vecs[i].exp_rd);
    end
    expect_sig("mepc_out", mepc, 32'h1234_5674);
    expect_sig("trap_address_after_write", trap_address, 32'h200);
    expect_sig("mie_enables", {29'b0, meie, mtie, msie}, 32'h5);

    // Trap entry followed by MRET.
    sync();
    csr_write(12'h300, 3'b110, 32'h0, 5'h08);
    expect_read("mstatus_mie_set", 12'h300, 32'h0000_1888);
    set_cause = 1; i_or_e = 1; cause = 4'd7; set_epc = 1; pc = 32'h0000_0207; iaddr = 32'h0000_BAD0;
    sync();
    set_cause = 0; set_epc = 0; i_or_e = 0; cause = '0;
    expect_read("trap_mcause", 12'h342, 32'h8000_0007);
    expect_read("trap_mepc", 12'h341, 32'h0000_0204);
    expect_read("trap_mtval", 12'h343, 32'h0000_BAD0);
    expect_read("trap_mstatus", 12'h300, 32'h0000_1880);
    expect_sig("trap_mie_out", {31'b0, mie}, 32'h0);
    mret = 1;
    sync();
    mret = 0;
    expect_sig("mret_mie_out", {31'b0, mie}, 32'h1);
    expect_read("mret_mstatus", 12'h300, 32'h0000_1888);

    // Trap entry outranks a same-cycle mstatus write.
    sync();
    set_cause = 1; i_or_e = 0; cause = 4'd2;
    csr_write(12'h300, 3'b001, 32'h0000_0008, 5'h00);
    set_cause = 0;
    expect_read("trap_beats_write_mstatus", 12'h300, 32'h0000_1880);
    expect_read("trap_beats_write_mcause", 12'h342, 32'h0000_0002);
    // MRET outranks a same-cycle mstatus write.
    mret = 1;
    csr_write(12'h300, 3'b001, 32'h0000_0000, 5'h00);
    mret = 0;
    expect_read("mret_beats_write_mstatus", 12'h300, 32'h0000_1888);

    // Interrupt lines are visible in mip one edge later.
    sync();
    e_irq = 1; s_irq = 1;
    #1;
    expect_sig("mip_not_yet", {29'b0, meip, mtip, msip}, 32'h0);
    sync();
    expect_sig("mip_bits", {29'b0, meip, mtip, msip}, 32'h5);
    expect_read("mip_read", 12'h344, 32'h0000_0808);
    e_irq = 0; s_irq = 0; t_irq = 1;
    sync();
    expect_read("mip_timer", 12'h344, 32'h0000_0080);
    t_irq = 0;

    // mcycle carry across the halves, and minstret override plus increments.
    sync();
    csr_write(12'hB00, 3'b001, 32'hFFFF_FFFF, 5'h00);
    csr_write(12'hB80, 3'b001, 32'h0000_0000, 5'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
`ifdef MSRV32_CSR_COUNTERS_EN
    expect_read("mcycle_after_wrap", 12'hB00, 32'h1);
    expect_read("mcycleh_after_wrap", 12'hB80, 32'h1);
`else
    expect_read("mcycle_absent", 12'hB00, 32'h0);
    expect_read("mcycleh_absent", 12'hB80, 32'h0);
`endif
    sync();
    instret_inc = 1;
    csr_write(12'hB02, 3'b001, 32'h0000_0005, 5'h00);
    repeat (3) @(posedge clk);
    #1;
    instret_inc = 0;
`ifdef MSRV32_CSR_COUNTERS_EN
    expect_read("minstret_count", 12'hB02, 32'h8);
`else
    expect_read("minstret_absent", 12'hB02, 32'h0);
`endif
    expect_read("minstreth", 12'hB82, 32'h0);

    // Unimplemented address: flagged, reads zero, changes nothing.
    sync();
    csr_addr = 12'h7C0; csr_op = 3'b001; csr_wr_en = 1'b1; rs1 = 32'hFFFF_FFFF;
    #1;
    expect_sig("illegal_flag", {31'b0, illegal_csr}, 32'h1);
    expect_sig("illegal_data", csr_data, 32'h0);
    @(posedge clk);
    #1;
    csr_wr_en = 1'b0;
    #1;
    expect_sig("illegal_idle", {31'b0, illegal_csr}, 32'h0);
    expect_read("illegal_keeps_mscratch", 12'h340, 32'h0000_0015);
    expect_read("illegal_keeps_mtvec", 12'h305, 32'h0000_0200);
    expect_read("illegal_keeps_mie", 12'h304, 32'h0000_0808);

    // Reset in the same cycle as a write and a trap drops both.
    sync();
    rst = 1; set_cause = 1; cause = 4'd11;
    csr_write(12'h340, 3'b001, 32'h0000_1234, 5'h00);
    rst = 0; set_cause = 0;
    expect_read("reset_drops_write", 12'h340, 32'h0);
    expect_read("reset_drops_trap", 12'h342, 32'h0);
    expect_read("reset_mtvec_again", 12'h305, 32'h0000_0100);
    expect_read("reset_mstatus_again", 12'h300, 32'h0000_1880);

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic [11:0] CSR_MIP_ADDR();
    return 12'h344;
  endfunction

endmodule
